// File: rtl/ide_spi_master_if.sv
// Host command / sector-word handshake plus the SPI pins of ide_spi_master.
interface ide_spi_master_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned STAT_W = 64;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned WORD_W = 16;

    logic              cmd_valid;
    logic [OP_W-1:0]   cmd_op;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic [STAT_W-1:0] status_out;
    logic              wr_req;
    logic [IDX_W-1:0]  wr_index;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              spi_ss1;
    logic              spi_ss2;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (
        input  cmd_valid, cmd_op, wr_data, spi_miso,
        output cmd_ready, busy, done, status_out, wr_req, wr_index,
               rd_data, rd_valid, spi_ss1, spi_ss2, spi_sclk, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_op, wr_data, spi_miso,
        input  cmd_ready, busy, done, status_out, wr_req, wr_index,
               rd_data, rd_valid, spi_ss1, spi_ss2, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/ide_spi_master.sv
// SPI master for an IDE bridge: status read on ss1, opcode-prefixed sector and
// command-file transfers on ss2, mode-0 style timing with a CLK_DIV half-period.
module ide_spi_master #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned SECTOR_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    ide_spi_master_if.master bus
);
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned IDX_W    = 9;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned STAT_W   = 64;
    localparam int unsigned MAX_BITS = 8 + WORD_W * (SECTOR_WORDS + 4);
    localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0]       OP_STATUS  = 2'b00;
    localparam logic [1:0]       OP_SREAD   = 2'b01;
    localparam logic [1:0]       OP_SWRITE  = 2'b10;
    localparam logic [7:0]       OPC_SREAD  = 8'h00;
    localparam logic [7:0]       OPC_SWRITE = 8'h80;
    localparam logic [7:0]       OPC_CFILE  = 8'h40;

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_SHIFT, S_DESEL} state_t;

    state_t              state, state_n;
    logic [1:0]          op, op_n;
    logic [DIV_W-1:0]    div_cnt, div_cnt_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n, bit_last, bit_last_n;
    logic [IDX_W-1:0]    word_last, word_last_n, wr_index, wr_index_n;
    logic                desel_late, desel_late_n;
    logic [WORD_W-2:0]   tx, tx_n;
    logic [WORD_W-1:0]   word_buf, word_buf_n;
    logic                buf_load, buf_load_n;
    logic [STAT_W-2:0]   rx, rx_n;
    logic [STAT_W-1:0]   status, status_n;
    logic [WORD_W-1:0]   rd_data, rd_data_n;
    logic                rd_valid, rd_valid_n;
    logic                ss1, ss1_n, ss2, ss2_n, sclk, sclk_n, mosi, mosi_n;
    logic                cmd_ready, cmd_ready_n, busy, busy_n, done, done_n;
    logic                wr_req, wr_req_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op         <= OP_STATUS;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bit_last   <= '0;
            word_last  <= '0;
            wr_index   <= '0;
            desel_late <= 1'b0;
            tx         <= '0;
            word_buf   <= '0;
            buf_load   <= 1'b0;
            rx         <= '0;
            status     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            ss1        <= 1'b1;
            ss2        <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_req     <= 1'b0;
        end else begin
            state      <= state_n;
            op         <= op_n;
            div_cnt    <= div_cnt_n;
            bit_cnt    <= bit_cnt_n;
            bit_last   <= bit_last_n;
            word_last  <= word_last_n;
            wr_index   <= wr_index_n;
            desel_late <= desel_late_n;
            tx         <= tx_n;
            word_buf   <= word_buf_n;
            buf_load   <= buf_load_n;
            rx         <= rx_n;
            status     <= status_n;
            rd_data    <= rd_data_n;
            rd_valid   <= rd_valid_n;
            ss1        <= ss1_n;
            ss2        <= ss2_n;
            sclk       <= sclk_n;
            mosi       <= mosi_n;
            cmd_ready  <= cmd_ready_n;
            busy       <= busy_n;
            done       <= done_n;
            wr_req     <= wr_req_n;
        end
    end

    always_comb begin
        state_n      = state;
        op_n         = op;
        div_cnt_n    = div_cnt;
        bit_cnt_n    = bit_cnt;
        bit_last_n   = bit_last;
        word_last_n  = word_last;
        wr_index_n   = wr_index;
        desel_late_n = desel_late;
        tx_n         = tx;
        word_buf_n   = word_buf;
        buf_load_n   = wr_req;
        rx_n         = rx;
        status_n     = status;
        rd_data_n    = rd_data;
        rd_valid_n   = 1'b0;
        ss1_n        = ss1;
        ss2_n        = ss2;
        sclk_n       = sclk;
        mosi_n       = mosi;
        busy_n       = busy;
        done_n       = 1'b0;
        wr_req_n     = 1'b0;

        // Requested word arrives one cycle after wr_req and waits here until its slot
        if (buf_load) word_buf_n = bus.wr_data;

        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_n    = S_SEL;
                    op_n       = bus.cmd_op;
                    div_cnt_n  = '0;
                    bit_cnt_n  = '0;
                    busy_n     = 1'b1;
                    ss1_n      = (bus.cmd_op != OP_STATUS);
                    ss2_n      = (bus.cmd_op == OP_STATUS);
                    wr_index_n = '0;
                    wr_req_n   = bus.cmd_op[1];
                    case (bus.cmd_op)
                        OP_STATUS: begin
                            bit_last_n = BIT_W'(STAT_W - 1);
                            tx_n       = '0;
                            mosi_n     = 1'b0;
                        end
                        OP_SREAD: begin
                            bit_last_n = BIT_W'(8 + WORD_W * SECTOR_WORDS - 1);
                            tx_n       = {OPC_SREAD[6:0], 8'h00};
                            mosi_n     = OPC_SREAD[7];
                        end
                        OP_SWRITE: begin
                            bit_last_n  = BIT_W'(MAX_BITS - 1);
                            word_last_n = IDX_W'(SECTOR_WORDS + 3);
                            tx_n        = {OPC_SWRITE[6:0], 8'h00};
                            mosi_n      = OPC_SWRITE[7];
                        end
                        default: begin
                            bit_last_n  = BIT_W'(8 + 4 * WORD_W - 1);
                            word_last_n = IDX_W'(3);
                            tx_n        = {OPC_CFILE[6:0], 8'h00};
                            mosi_n      = OPC_CFILE[7];
                        end
                    endcase
                end
            end

            S_SEL: begin
                if (div_cnt == DIV_LAST) begin
                    state_n   = S_SHIFT;
                    div_cnt_n = '0;
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end

            S_SHIFT: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end else if (!sclk) begin
                    // Rising edge: sample miso in the same cycle sclk goes high
                    div_cnt_n = '0;
                    sclk_n    = 1'b1;
                    rx_n      = {rx[STAT_W-3:0], bus.spi_miso};
                    if (op == OP_STATUS && bit_cnt == BIT_W'(STAT_W - 1))
                        status_n = {rx, bus.spi_miso};
                    if (op == OP_SREAD && bit_cnt >= BIT_W'(8) && bit_cnt[3:0] == 4'd7) begin
                        rd_data_n  = {rx[WORD_W-2:0], bus.spi_miso};
                        rd_valid_n = 1'b1;
                    end
                end else begin
                    div_cnt_n = '0;
                    sclk_n    = 1'b0;
                    if (bit_cnt == bit_last) begin
                        state_n      = S_DESEL;
                        desel_late_n = 1'b0;
                        mosi_n       = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        // Bit 7 ends the opcode and every 16 bits after that end a word
                        if (op[1] && bit_cnt[3:0] == 4'd7) begin
                            tx_n   = word_buf[WORD_W-2:0];
                            mosi_n = word_buf[WORD_W-1];
                            if (wr_index != word_last) begin
                                wr_req_n   = 1'b1;
                                wr_index_n = wr_index + IDX_W'(1);
                            end
                        end else begin
                            tx_n   = {tx[WORD_W-3:0], 1'b0};
                            mosi_n = tx[WORD_W-2];
                        end
                    end
                end
            end

            S_DESEL: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end else if (!desel_late) begin
                    div_cnt_n    = '0;
                    desel_late_n = 1'b1;
                    ss1_n        = 1'b1;
                    ss2_n        = 1'b1;
                end else begin
                    div_cnt_n = '0;
                    state_n   = S_IDLE;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                end
            end
        endcase
    end

    // Held low during the done cycle so done never coincides with an accept
    assign cmd_ready_n = (state_n == S_IDLE) && !done_n;

    assign bus.cmd_ready  = cmd_ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.status_out = status;
    assign bus.wr_req     = wr_req;
    assign bus.wr_index   = wr_index;
    assign bus.rd_data    = rd_data;
    assign bus.rd_valid   = rd_valid;
    assign bus.spi_ss1    = ss1;
    assign bus.spi_ss2    = ss2;
    assign bus.spi_sclk   = sclk;
    assign bus.spi_mosi   = mosi;
endmodule
